cofactor_accum: RTL and testbench

COFACTOR_ACCUM -- requirements
Module: cofactor_accum

---
 rtl/cofactor_accum.sv | 120 ++++++++++++
 tb/tb_cofactor_accum.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cofactor_accum.sv
// Alternating-sign accumulator for determinant cofactor terms: t0 - t1 + t2 - ...
// Optional sticky signed-overflow flag enabled by defining COFACTOR_OVF_EN.
module cofactor_accum #(
   parameter int WIDTH  = 32,
   parameter int NTERMS = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_term,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff_out
`ifdef COFACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int IW = $clog2(NTERMS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NTERMS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [IW-1:0]    idx_reg, idx_next;
   logic             rdy_en_reg;
   logic             accept;
   logic [WIDTH-1:0] sum, diff;

   // Readiness is held off until the first clock edge after reset release.
   assign in_ready  = rdy_en_reg && (state_reg != DONE);
   assign out_valid = (state_reg == DONE);
   assign Diff_out  = acc_reg;
   assign accept    = in_valid && in_ready;
   assign sum       = acc_reg + in_term;
   assign diff      = acc_reg - in_term;

`ifdef COFACTOR_OVF_EN
   logic ovf_reg, ovf_next, step_ovf;
   assign ovf = ovf_reg;
   // Signed overflow: operand signs (after negation for subtract) agree but result sign differs.
   always_comb begin
      step_ovf = 1'b0;
      if (idx_reg[0])
         step_ovf = (acc_reg[WIDTH-1] != in_term[WIDTH-1]) && (diff[WIDTH-1] != acc_reg[WIDTH-1]);
      else
         step_ovf = (acc_reg[WIDTH-1] == in_term[WIDTH-1]) && (sum[WIDTH-1] != acc_reg[WIDTH-1]);
   end
`endif

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      idx_next   = idx_reg;
`ifdef COFACTOR_OVF_EN
      ovf_next   = ovf_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (accept) begin
               acc_next   = in_term;
               idx_next   = IW'(1);
               state_next = ACCUM;
`ifdef COFACTOR_OVF_EN
               ovf_next   = 1'b0;
`endif
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_next = idx_reg[0] ? diff : sum;
               idx_next = idx_reg + IW'(1);
               if (idx_reg == LAST_IDX)
                  state_next = DONE;
`ifdef COFACTOR_OVF_EN
               ovf_next = ovf_reg | step_ovf;
`endif
            end
         end
         DONE: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (clr) begin
         state_next = IDLE;
         acc_next   = '0;
         idx_next   = '0;
`ifdef COFACTOR_OVF_EN
         ovf_next   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         acc_reg    <= '0;
         idx_reg    <= '0;
         rdy_en_reg <= 1'b0;
`ifdef COFACTOR_OVF_EN
         ovf_reg    <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         idx_reg    <= idx_next;
         rdy_en_reg <= 1'b1;
`ifdef COFACTOR_OVF_EN
         ovf_reg    <= ovf_next;
`endif
      end
   end

endmodule

// File: tb/tb_cofactor_accum.sv
// Directed-vector bench for cofactor_accum (NTERMS=3, WIDTH=32); ovf checks when COFACTOR_OVF_EN is defined.
module tb_cofactor_accum;

   logic        clk = 1'b0;
   logic        rst_n, clr, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_term, diff_out;
`ifdef COFACTOR_OVF_EN
   logic        ovf;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;
   int accepts = 0;

   always #5 clk = ~clk;

   cofactor_accum #(.WIDTH(32), .NTERMS(3)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_term(in_term),
      .out_valid(out_valid), .out_ready(out_ready), .Diff_out(diff_out)
`ifdef COFACTOR_OVF_EN
      , .ovf(ovf)
`endif
   );

   always @(posedge clk) if (in_valid && in_ready) accepts++;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else
         $display("ok   %s: 0x%08h", tag, obs);
   endtask

   // Present one term and hold it until accepted (bounded).
   task automatic send(input logic [31:0] t);
      int n = 0;
      in_valid = 1'b1;
      in_term  = t;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) check_val("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_term = '0;
      #12;
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_diff", diff_out, 32'd0);
      @(negedge clk); rst_n = 1'b1; #1;
      check_val("pre_edge_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check_val("post_edge_in_ready", {31'd0, in_ready}, 32'd1);

      // 5 - 3 + 7 = 9
      send(32'd5); send(32'd3);
      check_val("run1_partial", diff_out, 32'd2);
      check_val("run1_not_done", {31'd0, out_valid}, 32'd0);
      send(32'd7);
      check_val("run1_valid", {31'd0, out_valid}, 32'd1);
      check_val("run1_diff", diff_out, 32'd9);
      consume();
      check_val("run1_idle_valid", {31'd0, out_valid}, 32'd0);

      // -4 - 6 + 2 = -8, consumer stalls 5 cycles
      send(-32'sd4); send(32'd6); send(32'd2);
      for (int i = 0; i < 5; i++) begin
         check_val("stall_diff", diff_out, 32'hFFFF_FFF8);
         check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      check_val("stall_still_valid", {31'd0, out_valid}, 32'd1);
      consume();
      check_val("stall_released", {31'd0, out_valid}, 32'd0);
      check_val("stall_idle_ready", {31'd0, in_ready}, 32'd1);

      // 0x7FFFFFFF - (-1) + 0 wraps to 0x80000000
      send(32'h7FFF_FFFF); send(32'hFFFF_FFFF); send(32'd0);
      check_val("wrap_diff", diff_out, 32'h8000_0000);
`ifdef COFACTOR_OVF_EN
      check_val("wrap_ovf", {31'd0, ovf}, 32'd1);
`endif
      consume();
      send(32'd1);
`ifdef COFACTOR_OVF_EN
      check_val("ovf_cleared", {31'd0, ovf}, 32'd0);
`endif
      send(32'd1); send(32'd1);
      check_val("after_wrap_diff", diff_out, 32'd1);
      consume();

      // clr together with second term's accept
      send(32'd3);
      in_valid = 1'b1; in_term = 32'd9; clr = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; clr = 1'b0;
      check_val("clr_diff", diff_out, 32'd0);
      check_val("clr_idle_ready", {31'd0, in_ready}, 32'd1);
      check_val("clr_out_valid", {31'd0, out_valid}, 32'd0);
      send(32'd1); send(32'd1); send(32'd1);
      check_val("post_clr_diff", diff_out, 32'd1);
      check_val("post_clr_valid", {31'd0, out_valid}, 32'd1);
      consume();

      // async reset mid-accumulation
      send(32'd4);
      #2 rst_n = 1'b0; #1;
      check_val("async_rst_diff", diff_out, 32'd0);
      check_val("async_rst_ready", {31'd0, in_ready}, 32'd0);
      check_val("async_rst_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      send(32'd2); send(32'd5); send(32'd1);
      check_val("post_rst_diff", diff_out, 32'hFFFF_FFFE);
      consume();

      // in_valid toggling 1-0-1-0-1: 10 - 4 + 3 = 9
      accepts = 0;
      in_valid = 1'b1; in_term = 32'd10; @(posedge clk); #1;
      in_valid = 1'b0;                   @(posedge clk); #1;
      in_valid = 1'b1; in_term = 32'd4;  @(posedge clk); #1;
      in_valid = 1'b0;                   @(posedge clk); #1;
      in_valid = 1'b1; in_term = 32'd3;  @(posedge clk); #1;
      in_valid = 1'b0;
      check_val("toggle_diff", diff_out, 32'd9);
      check_val("toggle_valid", {31'd0, out_valid}, 32'd1);
      check_val("toggle_accepts", accepts, 32'd3);
      consume();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
